// File: rtl/input_port_pkg.sv
// Shared defaults and width helpers for the CPU input port.
// Optional sticky overflow flag is enabled by defining INPUT_PORT_OVF_EN.
package input_port_pkg;

    localparam int IP_DATA_WIDTH = 16;
    localparam int IP_DEPTH      = 4;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy must represent 0..depth inclusive, hence one extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/strobe_sync_edge.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge detector.
module strobe_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= async_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign rise = r_s2 & ~r_prev;

endmodule

// File: rtl/input_fifo_port.sv
// CPU-side input port: captures words on an async strobe into a show-ahead FIFO.
// Define INPUT_PORT_OVF_EN to enable the sticky overflow flag; otherwise overflow is tied 0.
module input_fifo_port
    import input_port_pkg::*;
#(
    parameter int DATA_WIDTH = IP_DATA_WIDTH,
    parameter int DEPTH      = IP_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [DATA_WIDTH-1:0]     ext_data,
    input  logic                      ext_strobe,
    output logic                      ext_ready,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      input_valid,
    input  logic                      inputRead,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    input  logic                      overflow_clear
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_ready;

    logic                  w_rise;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [CNT_W-1:0]      w_cnt_nxt;

    strobe_sync_edge u_strobe_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (ext_strobe),
        .rise     (w_rise)
    );

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = inputRead && !w_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign w_push  = w_rise && (!w_full || w_pop);
    assign w_drop  = w_rise && w_full && !w_pop;

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_push && !w_pop)
            w_cnt_nxt = r_count + CNT_W'(1);
        else if (!w_push && w_pop)
            w_cnt_nxt = r_count - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= ext_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_count <= w_cnt_nxt;
            r_ready <= (w_cnt_nxt != CNT_W'(DEPTH));
        end
    end

    assign ext_ready   = r_ready;
    assign count       = r_count;
    assign input_valid = !w_empty;
    assign data_out    = w_empty ? '0 : r_mem[r_rd_ptr];

`ifdef INPUT_PORT_OVF_EN
    logic r_ovf;

    // A drop on the clearing edge keeps the flag set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
        else if (overflow_clear)
            r_ovf <= 1'b0;
    end

    assign overflow = r_ovf;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = overflow_clear | w_drop;
    assign overflow     = 1'b0;
`endif

endmodule
